// File: rtl/ib_lut_mem_pingpong.sv
// Double-buffered LUT memory for the IB decoder LUT cells.
// The decoder reads the active bank through RD_PORT_NUM replicated copies.
// At the same time, a streaming loader fills the shadow bank.
// A swap command exchanges the roles of the two banks.
module ib_lut_mem_pingpong #(
  parameter int unsigned QUAN_SIZE     = 4,
  parameter int unsigned PAGE_NUM      = 32,
  parameter int unsigned ADDR_BITWIDTH = $clog2(PAGE_NUM),
  parameter int unsigned RD_PORT_NUM   = 2,
  parameter bit          ASYNC_RD      = 1'b1
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst,
  input  logic                                 load_start_i,
  input  logic [QUAN_SIZE-1:0]                 load_data_i,
  input  logic                                 load_valid_i,
  output logic                                 load_ready_o,
  output logic                                 load_busy_o,
  output logic                                 load_done_o,
  output logic                                 load_err_o,
  input  logic                                 bank_swap_i,
  output logic                                 active_bank_o,
  input  logic [RD_PORT_NUM*ADDR_BITWIDTH-1:0] read_addr_i,
  output logic [RD_PORT_NUM*QUAN_SIZE-1:0]     read_page_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                   state_q;
  logic [ADDR_BITWIDTH-1:0] wr_ptr_q;
  logic                     load_bank_q;
  logic                     active_bank_q;
  logic                     ready_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;

  // Each bank has one copy per read port.
  // Each copy is a simple dual-port distributed RAM.
  logic [QUAN_SIZE-1:0] mem_q [2][RD_PORT_NUM][PAGE_NUM];

  logic wr_en;
  logic last_word;

  // ready_q is high exactly while in StLoad.
  // Writes are gated during reset so an aborted load stops at once.
  assign wr_en     = ready_q & load_valid_i & ~sys_rst;
  assign last_word = (wr_ptr_q == ADDR_BITWIDTH'(PAGE_NUM - 1));

  assign load_ready_o  = ready_q;
  assign load_busy_o   = busy_q;
  assign load_done_o   = done_q;
  assign load_err_o    = err_q;
  assign active_bank_o = active_bank_q;

  // Loader FSM with registered status outputs and the active-bank flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      load_bank_q   <= 1'b1;
      active_bank_q <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bank_swap_i) active_bank_q <= ~active_bank_q;
          if (load_start_i) begin
            state_q     <= StLoad;
            wr_ptr_q    <= '0;
            // A same-edge swap applies first.
            // The load therefore targets the bank that just became inactive.
            load_bank_q <= ~(active_bank_q ^ bank_swap_i);
            ready_q     <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StLoad: begin
          // Swapping mid-load would expose a half-written bank, so refuse it.
          if (bank_swap_i) err_q <= 1'b1;
          if (load_valid_i) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (last_word) begin
              state_q <= StDone;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          if (bank_swap_i) active_bank_q <= ~active_bank_q;
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Shadow-bank write, broadcast to every read-port copy.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      for (int p = 0; p < RD_PORT_NUM; p++) begin
        mem_q[load_bank_q][p][wr_ptr_q] <= load_data_i;
      end
    end
  end

  for (genvar p = 0; p < RD_PORT_NUM; p++) begin : g_rd_port
    logic [ADDR_BITWIDTH-1:0] rd_addr;
    logic [QUAN_SIZE-1:0]     rd_word;

    assign rd_addr = read_addr_i[p*ADDR_BITWIDTH +: ADDR_BITWIDTH];
    // Addresses past the end of the page exist only when PAGE_NUM is not a power of two.
    assign rd_word = (32'(rd_addr) < PAGE_NUM) ? mem_q[active_bank_q][p][rd_addr] : '0;

    if (ASYNC_RD) begin : g_async
      assign read_page_o[p*QUAN_SIZE +: QUAN_SIZE] = rd_word;
    end else begin : g_sync
      logic [QUAN_SIZE-1:0] rd_q;

      // Registered read: one cycle of latency from address to data.
      always_ff @(posedge sys_clk) begin
        if (sys_rst) rd_q <= '0;
        else         rd_q <= rd_word;
      end

      assign read_page_o[p*QUAN_SIZE +: QUAN_SIZE] = rd_q;
    end
  end

endmodule

// File: doc/ib_lut_mem_pingpong.md
Name: ib_lut_mem_pingpong

Overview:
- Parametrised, double-buffered LUT memory for the IB decoder LUT cells.
- Holds two LUT sets (bank 0 and bank 1), each replicated once per read port so every port has an independent read.
- A streaming loader FSM fills the shadow (inactive) bank while the decoder reads the active bank; a swap command flips the roles.
- Sits between the LUT configuration stream and the IB variable/check-node LUT cells.

Parameters:
- QUAN_SIZE, 4, bits per LUT word.
- PAGE_NUM, 32, words per bank; any value 2..1024.
- ADDR_BITWIDTH, $clog2(PAGE_NUM), address width; do not override.
- RD_PORT_NUM, 2, number of independent read ports (replicated copies).
- ASYNC_RD, 1, 1 = combinational read, 0 = registered read with 1-cycle latency.

Ports:
- sys_clk  in  1  single clock; all logic on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- load_start_i  in  1  starts a load of the shadow bank.
- load_data_i  in  QUAN_SIZE  LUT word being loaded.
- load_valid_i  in  1  load_data_i is valid.
- load_ready_o  out  1  loader accepts a word this cycle.
- load_busy_o  out  1  FSM is in LOAD or DONE.
- load_done_o  out  1  one-cycle pulse when the last word is written.
- load_err_o  out  1  one-cycle pulse when a swap request is rejected.
- bank_swap_i  in  1  request to swap active and shadow banks.
- active_bank_o  out  1  index of the bank currently being read.
- read_addr_i  in  RD_PORT_NUM*ADDR_BITWIDTH  port p address at slice [p*ADDR_BITWIDTH +: ADDR_BITWIDTH].
- read_page_o  out  RD_PORT_NUM*QUAN_SIZE  port p data at slice [p*QUAN_SIZE +: QUAN_SIZE].

Behaviour:
- Reset values: active_bank_o=0, FSM=IDLE, wr_ptr=0, load_ready_o=0, load_busy_o=0, load_done_o=0, load_err_o=0. When ASYNC_RD=0, the read_page_o register is 0. Memory contents are not reset.
- Reset mid-load aborts the load. The shadow bank contents are then undefined and must be reloaded.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on load_start_i. wr_ptr clears to 0. load_bank is latched as the inverse of the active bank value that holds after any same-edge swap.
  - LOAD: load_ready_o=1, load_busy_o=1. Each cycle with load_valid_i & load_ready_o writes load_data_i to address wr_ptr of load_bank, in all RD_PORT_NUM copies. wr_ptr then increments.
  - An accept at wr_ptr==PAGE_NUM-1 moves the FSM to DONE. Valid without ready writes nothing.
  - DONE (one cycle): load_done_o=1, load_ready_o=0, load_busy_o=1; then -> IDLE.
- load_start_i is ignored in LOAD and DONE.
- Swap rules:
  - bank_swap_i in IDLE or DONE toggles active_bank_o at the same edge; the new value is visible the next cycle.
  - bank_swap_i in LOAD is ignored, and load_err_o=1 for the following cycle.
  - Simultaneous load_start_i and bank_swap_i in IDLE: both are honoured. The swap applies first, so the load targets the bank that just became inactive.
- Writes only ever hit the shadow bank. There are no read/write collisions on the active bank.
- ASYNC_RD=1: read_page_o[p] = mem[active_bank_o][p][read_addr_p], combinational.
- ASYNC_RD=0: read_page_o[p] is registered at the rising edge. It uses the address and active_bank_o present in the cycle before the edge, giving 1-cycle latency.
- A read address >= PAGE_NUM returns 0 (only possible when PAGE_NUM is not a power of two).
- The write port is synchronous on sys_clk. Storage maps to LUTRAM/distributed RAM (simple dual-port per copy).

Test Plan:
- Reset, then pulse load_start_i and stream 32 words 0..15,0..15 with valid held high → load_ready_o high for exactly 32 cycles, load_done_o pulses once on cycle 33, active_bank_o stays 0.
- After the load, pulse bank_swap_i, then drive port0 addr 5 and port1 addr 20 → with ASYNC_RD=1, active_bank_o=1 and same-cycle data 5 and 4; with ASYNC_RD=0, the same values appear one cycle later.
- During LOAD, toggle load_valid_i randomly (~50%) → exactly 32 writes, wr_ptr advances only on accepts, and contents match the accepted order.
- Assert bank_swap_i at word 10 of a load → active_bank_o unchanged, load_err_o pulses for one cycle, load completes normally.
- Assert load_start_i and bank_swap_i together in IDLE with active_bank_o=1 → active_bank_o becomes 0 and the load writes bank 1. Port reads of bank 0 are unaffected throughout.
- Assert sys_rst at word 17 of a load → all outputs return to reset values next cycle, active_bank_o=0. A subsequent full load plus swap reads back correct data.
